regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised register file with a per-register write-reservation scoreboard, sitting between the decode stage (reads, reservations) and the exec/write-back stage.
- Successor to the fixed four-entry file with one-bit reservations (r0..r3 and w_reserve).
- Generalised in register count, data width and read-port count.
- Adds counted multiple outstanding reservations, hazard/stall generation and a sticky protocol-error flag.

Parameters:
- NREG, 4, number of architectural registers (power of two, >=2).
- WIDTH, 32, data width per register.
- NRD, 2, number of read ports (rd, rs generalised).
- MAXPEND, 3, max outstanding reservations per register (1..7); counter width CW = clog2(MAXPEND+1).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous reset, active low.
- rd_valid  in  NRD  per-port read request.
- rd_idx  in  NRD*clog2(NREG)  packed read indices, port 0 in LSBs.
- rd_data  out  NRD*WIDTH  packed read data, combinational.
- hazard  out  1  some valid read port targets a register with a pending reservation.
- rsv_valid  in  1  reserve destination this cycle.
- rsv_idx  in  clog2(NREG)  register to reserve.
- rsv_stall  out  1  reservation refused (counter saturated).
- wb_valid  in  1  write-back strobe.
- wb_idx  in  clog2(NREG)  write-back register.
- wb_data  in  WIDTH  write-back data.
- pend  out  NREG  per-register "count != 0" vector (debug / wb_reserved).
- wb_err  out  1  sticky: write-back to a register with count 0.

Behaviour:
- Reset (rst==0 at posedge): all data = 0, all counts = 0, wb_err = 0.
  - While in reset: hazard = 0, rsv_stall = 0, pend = 0.
  - Reset overrides any same-cycle rsv/wb.
- State per register i: data[i] (WIDTH), cnt[i] (CW).
- Read:
  - rd_data[p] = data[rd_idx[p]], combinational, independent of rd_valid.
  - Index >= NREG is impossible (power of two).
- Hazard (combinational): OR over p of rd_valid[p] && cnt[rd_idx[p]] != 0.
- Reservation:
  - If rsv_valid and cnt[rsv_idx] < MAXPEND: cnt increments next edge, rsv_stall = 0.
  - If cnt == MAXPEND: rsv_stall = 1 combinationally and cnt is unchanged. The requester must hold and retry.
- Write-back:
  - wb_valid writes data[wb_idx] <= wb_data next edge.
  - If cnt != 0, cnt decrements.
  - If cnt == 0, data is still written, cnt stays 0 and wb_err sets (sticky until reset).
- Simultaneous rsv and wb, same register: net cnt unchanged; data written. Saturation check uses the pre-edge cnt, so at cnt==MAXPEND, rsv_stall = 1 and wb alone decrements.
- Simultaneous rsv and wb, different registers: independent.
- Latency:
  - Reservation is visible in hazard/pend the cycle after rsv_valid.
  - Write-back data is visible on rd_data the cycle after wb_valid (without bypass).
- No ordering of write-backs is enforced; the counter tracks only quantity.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - Same-cycle write-back forwarding: if wb_valid && wb_idx == rd_idx[p], then rd_data[p] = wb_data.
  - The hazard term for port p is suppressed when wb_valid && wb_idx == rd_idx[p] && cnt == 1 (the last pending writer completes this cycle).
- Undefined: reads see only registered data, and the hazard uses cnt alone.

Decomposition:
- Shared package/include (alongside the instruction defines): register-index width function, WIDTH default, the MAXPEND default.
- One natural sub-module, regfile_entry: holds data and cnt for one register, with inputs write-enable, inc, dec; outputs data and pend. Instantiated NREG times with a generate loop.
- Read muxes and hazard reduction stay in the parent.

Test Plan:
- Reset: rst=0 for 2 cycles with rsv_valid=1, wb_valid=1 -> all data 0, pend=0, wb_err=0 after release.
- Basic RAW hazard:
  - Cycle 0: rsv r1.
  - Cycle 1: read r1 on port 0 -> hazard=1.
  - Cycle 3: wb r1=0xDEADBEEF.
  - Cycle 4: rd_data[0]=0xDEADBEEF, hazard=0, pend=0.
- Saturation: 3 reserves of r2 -> cnt=3. 4th reserve -> rsv_stall=1, cnt stays 3. Same-cycle rsv+wb at cnt=3 -> cnt=2.
- Simultaneous rsv and wb on r3 at cnt=1 -> cnt stays 1, pend[3]=1, data updated to wb_data.
- Spurious wb to r0 with cnt=0, data 0x5 -> data[0]=5, wb_err=1 and it stays 1 through later valid traffic until rst=0.
- With REGFILE_BYPASS_EN, r1 cnt=1, wb r1=0x1234 while reading r1 -> same cycle rd_data=0x1234 and hazard=0. Without the macro -> hazard=1 and old data.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing helpers and defaults for the register file / reservation scoreboard.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Optional feature macro used by regfile_scoreboard: REGFILE_BYPASS_EN.
package regfile_scoreboard_pkg;

  localparam int NREG_DEFAULT    = 4;
  localparam int WIDTH_DEFAULT   = 32;
  localparam int NRD_DEFAULT     = 2;
  localparam int MAXPEND_DEFAULT = 3;

  // Register-index width; a single-register file still gets a 1-bit index.
  function automatic int idx_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  // Reservation counter width, wide enough to hold maxpend itself.
  function automatic int cnt_width(input int maxpend);
    return $clog2(maxpend + 1);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_entry.sv
// One architectural register: data word plus its outstanding-reservation counter.
// Latency: write and count changes are visible one cycle after the strobe.
// Backpressure: none here; the parent only raises inc when the counter has room.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   we_i, wdata_i       write-back strobe and data for this register
//   inc_i, dec_i        reservation accepted / pending writer retired this cycle
//   data_o, cnt_o       registered data and reservation count
//   pend_o              count != 0
module regfile_scoreboard_entry
  import regfile_scoreboard_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CW    = cnt_width(MAXPEND_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    cnt_o,
  output logic             pend_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (we_i) begin
      data_d = wdata_i;
    end
    // A simultaneous reserve and retire cancel out.
    if (inc_i && !dec_i) begin
      cnt_d = cnt_q + CW'(1);
    end else if (dec_i && !inc_i) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;
  assign pend_o = (cnt_q != '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register counted write reservations, RAW hazard and stall generation.
// Latency: reads combinational; reservations/write-backs visible the cycle after the strobe.
// Backpressure: rsv_stall refuses a reservation on a saturated counter; requester holds and retries.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write-back data onto
// matching read ports and to drop the hazard when that write retires the last pending writer.
//
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   rd_valid, rd_idx       per-port read request and packed indices (port 0 in LSBs)
//   rd_data                packed read data (port 0 in LSBs), combinational
//   hazard                 a valid read port targets a register with pending reservations
//   rsv_valid, rsv_idx     reserve a destination register
//   rsv_stall              reservation refused this cycle
//   wb_valid, wb_idx, wb_data  write-back strobe, register and data
//   pend                   per-register "count != 0"
//   wb_err                 sticky: a write-back hit a register with no reservation
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int NREG    = NREG_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int NRD     = NRD_DEFAULT,
  parameter int MAXPEND = MAXPEND_DEFAULT,
  localparam int IW     = idx_width(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD-1:0]       rd_valid,
  input  logic [NRD*IW-1:0]    rd_idx,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic                 hazard,
  input  logic                 rsv_valid,
  input  logic [IW-1:0]        rsv_idx,
  output logic                 rsv_stall,
  input  logic                 wb_valid,
  input  logic [IW-1:0]        wb_idx,
  input  logic [WIDTH-1:0]     wb_data,
  output logic [NREG-1:0]      pend,
  output logic                 wb_err
);

  localparam int             CW      = cnt_width(MAXPEND);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAXPEND);

  logic [WIDTH-1:0] data_arr [NREG];
  logic [CW-1:0]    cnt_arr  [NREG];
  logic [NREG-1:0]  pend_raw;
  logic [NRD-1:0]   rd_hit;

  // ---------------------------------------------------------------------------
  // Register entries
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NREG; i++) begin : g_entry
    logic we, inc, dec;

    assign we  = wb_valid && (wb_idx == IW'(i));
    // Saturation is judged on the pre-edge count, so a same-cycle retire
    // does not make room for a reservation that is already being refused.
    assign inc = rsv_valid && (rsv_idx == IW'(i)) && (cnt_arr[i] < CNT_MAX);
    // A write-back with nothing outstanding still writes data but leaves the count at 0.
    assign dec = we && (cnt_arr[i] != '0);

    regfile_scoreboard_entry #(
      .WIDTH (WIDTH),
      .CW    (CW)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we),
      .wdata_i (wb_data),
      .inc_i   (inc),
      .dec_i   (dec),
      .data_o  (data_arr[i]),
      .cnt_o   (cnt_arr[i]),
      .pend_o  (pend_raw[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Read muxes and per-port hazard terms
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [IW-1:0] sel;
    logic          pending;

    assign sel     = rd_idx[p*IW +: IW];
    assign pending = (cnt_arr[sel] != '0);

`ifdef REGFILE_BYPASS_EN
    logic fwd;
    assign fwd = wb_valid && (wb_idx == sel);
    assign rd_data[p*WIDTH +: WIDTH] = fwd ? wb_data : data_arr[sel];
    // The forwarded write is the only one outstanding, so the value on the
    // port is already final and the reader need not wait.
    assign rd_hit[p] = rd_valid[p] && pending && !(fwd && (cnt_arr[sel] == CW'(1)));
`else
    assign rd_data[p*WIDTH +: WIDTH] = data_arr[sel];
    assign rd_hit[p] = rd_valid[p] && pending;
`endif
  end

  // Status outputs are held quiet while reset is asserted, even before the
  // first reset edge has cleared the counters.
  assign hazard    = rst && (|rd_hit);
  assign rsv_stall = rst && rsv_valid && (cnt_arr[rsv_idx] == CNT_MAX);
  assign pend      = rst ? pend_raw : '0;

  // ---------------------------------------------------------------------------
  // Sticky protocol error: write-back to a register nobody reserved
  // ---------------------------------------------------------------------------
  logic wb_err_q, wb_err_d;

  assign wb_err_d = wb_err_q | (wb_valid && (cnt_arr[wb_idx] == '0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_err_q <= 1'b0;
    end else begin
      wb_err_q <= wb_err_d;
    end
  end

  assign wb_err = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (default parameters).
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_valid;
  logic [3:0]  rd_idx;
  logic [63:0] rd_data;
  logic        hazard;
  logic        rsv_valid;
  logic [1:0]  rsv_idx;
  logic        rsv_stall;
  logic        wb_valid;
  logic [1:0]  wb_idx;
  logic [31:0] wb_data;
  logic [3:0]  pend;
  logic        wb_err;

  int errors = 0;
  int checks = 0;

  regfile_scoreboard dut (
    .clk       (clk),
    .rst       (rst),
    .rd_valid  (rd_valid),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .hazard    (hazard),
    .rsv_valid (rsv_valid),
    .rsv_idx   (rsv_idx),
    .rsv_stall (rsv_stall),
    .wb_valid  (wb_valid),
    .wb_idx    (wb_idx),
    .wb_data   (wb_data),
    .pend      (pend),
    .wb_err    (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later,
  // well before the next rising edge commits the cycle.
  task automatic drive(input logic r, input logic rv, input logic [1:0] ri,
                       input logic wv, input logic [1:0] wi, input logic [31:0] wd,
                       input logic [1:0] rdv, input logic [1:0] i0, input logic [1:0] i1);
    @(negedge clk);
    rst       = r;
    rsv_valid = rv;
    rsv_idx   = ri;
    wb_valid  = wv;
    wb_idx    = wi;
    wb_data   = wd;
    rd_valid  = rdv;
    rd_idx    = {i1, i0};
    #1;
  endtask

  // Two reset cycles with live rsv/wb traffic, then read back every register.
  task automatic reset_seq(input string tag);
    drive(1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 32'hFFFF_FFFF, 2'b11, 2'd2, 2'd1);
    check({tag, " in-reset hazard"}, hazard, 0);
    check({tag, " in-reset pend"}, pend, 0);
    drive(1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 32'hFFFF_FFFF, 2'b11, 2'd2, 2'd1);
    check({tag, " in-reset stall"}, rsv_stall, 0);
    check({tag, " in-reset wb_err"}, wb_err, 0);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 2'b11, 2'd0, 2'd1);
    check({tag, " post rd r0"}, rd_data[31:0], 0);
    check({tag, " post rd r1"}, rd_data[63:32], 0);
    check({tag, " post pend"}, pend, 0);
    check({tag, " post wb_err"}, wb_err, 0);
    check({tag, " post hazard"}, hazard, 0);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 2'b00, 2'd2, 2'd3);
    check({tag, " post rd r2"}, rd_data[31:0], 0);
    check({tag, " post rd r3"}, rd_data[63:32], 0);
  endtask

  typedef struct {
    logic        rv;
    logic [1:0]  ri;
    logic        wv;
    logic [1:0]  wi;
    logic [31:0] wd;
    logic [1:0]  rdv;
    logic [1:0]  i0;
    logic [1:0]  i1;
    logic        e_haz;
    logic        e_stall;
    logic [3:0]  e_pend;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [1:0] ri, input logic wv,
                              input logic [1:0] wi, input logic [31:0] wd, input logic [1:0] rdv,
                              input logic [1:0] i0, input logic [1:0] i1, input logic eh,
                              input logic es, input logic [3:0] ep, input logic [31:0] e0,
                              input logic [31:0] e1, input logic ee);
    vec_t v;
    v.rv = rv; v.ri = ri; v.wv = wv; v.wi = wi; v.wd = wd;
    v.rdv = rdv; v.i0 = i0; v.i1 = i1;
    v.e_haz = eh; v.e_stall = es; v.e_pend = ep;
    v.e_rd0 = e0; v.e_rd1 = e1; v.e_err = ee;
    return v;
  endfunction

  localparam int NV = 23;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  vec_t vecs [NV];

  // Reference model state for the random phase.
  logic [31:0] data_m [4];
  int          cnt_m  [4];
  bit          err_m;

  initial begin
    rst = 1'b0; rsv_valid = 1'b0; rsv_idx = '0; wb_valid = 1'b0; wb_idx = '0;
    wb_data = '0; rd_valid = '0; rd_idx = '0;

    //            rv ri  wv wi wd            rdv    i0 i1   haz        stall pend     rd0                   rd1                  err
    vecs[0]  = mk(1, 1,  0, 0, 32'h0,        2'b01, 1, 1,   0,         0,    4'b0000, 32'h0,                32'h0,               0);
    vecs[1]  = mk(0, 0,  0, 0, 32'h0,        2'b01, 1, 1,   1,         0,    4'b0010, 32'h0,                32'h0,               0);
    vecs[2]  = mk(0, 0,  0, 0, 32'h0,        2'b01, 1, 1,   1,         0,    4'b0010, 32'h0,                32'h0,               0);
    vecs[3]  = mk(0, 0,  1, 1, DB,           2'b01, 1, 1,   !BYP,      0,    4'b0010, BYP ? DB : 32'h0,     BYP ? DB : 32'h0,    0);
    vecs[4]  = mk(0, 0,  0, 0, 32'h0,        2'b01, 1, 1,   0,         0,    4'b0000, DB,                   DB,                  0);
    vecs[5]  = mk(1, 2,  0, 0, 32'h0,        2'b00, 2, 1,   0,         0,    4'b0000, 32'h0,                DB,                  0);
    vecs[6]  = mk(1, 2,  0, 0, 32'h0,        2'b00, 2, 1,   0,         0,    4'b0100, 32'h0,                DB,                  0);
    vecs[7]  = mk(1, 2,  0, 0, 32'h0,        2'b00, 2, 1,   0,         0,    4'b0100, 32'h0,                DB,                  0);
    vecs[8]  = mk(1, 2,  0, 0, 32'h0,        2'b00, 2, 1,   0,         1,    4'b0100, 32'h0,                DB,                  0);
    vecs[9]  = mk(1, 2,  1, 2, 32'hAA,       2'b01, 2, 1,   1,         1,    4'b0100, BYP ? 32'hAA : 32'h0, DB,                  0);
    vecs[10] = mk(1, 2,  0, 0, 32'h0,        2'b00, 2, 1,   0,         0,    4'b0100, 32'hAA,               DB,                  0);
    vecs[11] = mk(0, 0,  1, 2, 32'hBB,       2'b01, 2, 1,   1,         0,    4'b0100, BYP ? 32'hBB : 32'hAA, DB,                 0);
    vecs[12] = mk(0, 0,  1, 2, 32'hCC,       2'b00, 2, 1,   0,         0,    4'b0100, BYP ? 32'hCC : 32'hBB, DB,                 0);
    vecs[13] = mk(0, 0,  1, 2, 32'hDD,       2'b01, 2, 1,   !BYP,      0,    4'b0100, BYP ? 32'hDD : 32'hCC, DB,                 0);
    vecs[14] = mk(0, 0,  0, 0, 32'h0,        2'b01, 2, 1,   0,         0,    4'b0000, 32'hDD,               DB,                  0);
    vecs[15] = mk(1, 3,  0, 0, 32'h0,        2'b00, 2, 3,   0,         0,    4'b0000, 32'hDD,               32'h0,               0);
    vecs[16] = mk(1, 3,  1, 3, 32'h33,       2'b10, 2, 3,   !BYP,      0,    4'b1000, 32'hDD,               BYP ? 32'h33 : 32'h0, 0);
    vecs[17] = mk(0, 0,  0, 0, 32'h0,        2'b10, 2, 3,   1,         0,    4'b1000, 32'hDD,               32'h33,              0);
    vecs[18] = mk(0, 0,  1, 0, 32'h5,        2'b01, 0, 1,   0,         0,    4'b1000, BYP ? 32'h5 : 32'h0,  DB,                  0);
    vecs[19] = mk(0, 0,  0, 0, 32'h0,        2'b01, 0, 1,   0,         0,    4'b1000, 32'h5,                DB,                  1);
    vecs[20] = mk(1, 1,  1, 3, 32'h77,       2'b00, 3, 1,   0,         0,    4'b1000, BYP ? 32'h77 : 32'h33, DB,                 1);
    vecs[21] = mk(0, 0,  1, 1, 32'h99,       2'b00, 3, 1,   0,         0,    4'b0010, 32'h77,               BYP ? 32'h99 : DB,   1);
    vecs[22] = mk(1, 2,  0, 0, 32'h0,        2'b00, 3, 1,   0,         0,    4'b0000, 32'h77,               32'h99,              1);

    reset_seq("init");

    for (int k = 0; k < NV; k++) begin
      drive(1'b1, vecs[k].rv, vecs[k].ri, vecs[k].wv, vecs[k].wi, vecs[k].wd,
            vecs[k].rdv, vecs[k].i0, vecs[k].i1);
      check($sformatf("v%0d hazard", k), hazard, vecs[k].e_haz);
      check($sformatf("v%0d rsv_stall", k), rsv_stall, vecs[k].e_stall);
      check($sformatf("v%0d pend", k), pend, vecs[k].e_pend);
      check($sformatf("v%0d rd0", k), rd_data[31:0], vecs[k].e_rd0);
      check($sformatf("v%0d rd1", k), rd_data[63:32], vecs[k].e_rd1);
      check($sformatf("v%0d wb_err", k), wb_err, vecs[k].e_err);
    end

    // r2 has one reservation outstanding here, so the reset must clear it.
    reset_seq("mid");

    // Randomised traffic against a rule-level model of the register file.
    for (int r = 0; r < 4; r++) begin
      data_m[r] = '0;
      cnt_m[r]  = 0;
    end
    err_m = 1'b0;

    for (int c = 0; c < 600; c++) begin
      logic        r_rst, r_rv, r_wv;
      logic [1:0]  r_ri, r_wi, r_rdv, r_i0, r_i1;
      logic [31:0] r_wd;
      logic [1:0]  sel [2];
      logic        exp_haz, exp_stall;
      logic [3:0]  exp_pend;
      logic [31:0] exp_rd [2];
      int          nxt [4];

      r_rst = ($urandom_range(0, 63) != 0);
      r_rv  = ($urandom_range(0, 1) == 1);
      r_ri  = 2'($urandom_range(0, 3));
      r_wv  = ($urandom_range(0, 9) < 4);
      r_wi  = 2'($urandom_range(0, 3));
      r_wd  = $urandom;
      r_rdv = 2'($urandom_range(0, 3));
      r_i0  = 2'($urandom_range(0, 3));
      r_i1  = 2'($urandom_range(0, 3));
      sel[0] = r_i0;
      sel[1] = r_i1;

      exp_haz  = 1'b0;
      exp_pend = '0;
      for (int q = 0; q < 4; q++) begin
        exp_pend[q] = r_rst && (cnt_m[q] > 0);
      end
      for (int p = 0; p < 2; p++) begin
        bit fwd;
        fwd = BYP && r_wv && (r_wi == sel[p]);
        exp_rd[p] = fwd ? r_wd : data_m[sel[p]];
        if (r_rst && r_rdv[p] && cnt_m[sel[p]] > 0 && !(fwd && cnt_m[sel[p]] == 1)) begin
          exp_haz = 1'b1;
        end
      end
      exp_stall = r_rst && r_rv && (cnt_m[r_ri] == 3);

      drive(r_rst, r_rv, r_ri, r_wv, r_wi, r_wd, r_rdv, r_i0, r_i1);
      check($sformatf("rnd%0d hazard", c), hazard, exp_haz);
      check($sformatf("rnd%0d rsv_stall", c), rsv_stall, exp_stall);
      check($sformatf("rnd%0d pend", c), pend, exp_pend);
      check($sformatf("rnd%0d rd0", c), rd_data[31:0], exp_rd[0]);
      check($sformatf("rnd%0d rd1", c), rd_data[63:32], exp_rd[1]);
      check($sformatf("rnd%0d wb_err", c), wb_err, err_m);

      // Commit the cycle in the model using pre-edge counts.
      if (!r_rst) begin
        for (int q = 0; q < 4; q++) begin
          data_m[q] = '0;
          cnt_m[q]  = 0;
        end
        err_m = 1'b0;
      end else begin
        for (int q = 0; q < 4; q++) nxt[q] = cnt_m[q];
        if (r_rv && cnt_m[r_ri] < 3) nxt[r_ri] = nxt[r_ri] + 1;
        if (r_wv) begin
          data_m[r_wi] = r_wd;
          if (cnt_m[r_wi] == 0) err_m = 1'b1;
          else nxt[r_wi] = nxt[r_wi] - 1;
        end
        for (int q = 0; q < 4; q++) cnt_m[q] = nxt[q];
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
